sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Single-clock, parametrised FIFO: the next-generation buffer for same-domain paths, where no clock-domain crossing is required. Data width, depth, almost-full/almost-empty thresholds and read mode (registered or first-word-fall-through) are all set by parameters. It also adds an occupancy count and overflow/underflow error pulses. It sits between a producer and a consumer on the same clock, and both sides use an enable/flag protocol.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- POINTER, 4, address bits; DEPTH = 1 << POINTER entries (POINTER ≥1)
- AF_TH, DEPTH-2, wr_almost_full asserts when count ≥ AF_TH (1..DEPTH)
- AE_TH, 2, rd_almost_empty asserts when count ≤ AE_TH (0..DEPTH-1)
- FWFT, 0, 0 = registered read, 1 = first-word-fall-through
- clk  input  1  single clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- wr_en  input  1  write request
- data_in  input  WIDTH  write data, sampled when the write is accepted
- wr_full  output  1  count == DEPTH
- wr_almost_full  output  1  count ≥ AF_TH
- wr_overflow  output  1  one-cycle pulse: a write was rejected
- rd_en  input  1  read request
- data_out  output  WIDTH  read data
- rd_empty  output  1  count == 0
- rd_almost_empty  output  1  count ≤ AE_TH
- rd_underflow  output  1  one-cycle pulse: a read was rejected
- count  output  POINTER+1  current occupancy, 0..DEPTH

## Operation
- Pointers: wr_ptr and rd_ptr are POINTER bits wide and wrap naturally modulo DEPTH. count is a separate POINTER+1-bit register.
- Write accept: wr_acc = wr_en & ~wr_full. On wr_acc, mem[wr_ptr] <= data_in and wr_ptr <= wr_ptr+1.
- Read accept: rd_acc = rd_en & ~rd_empty. On rd_acc, rd_ptr <= rd_ptr+1.
- count update:
  - +1 on wr_acc only.
  - −1 on rd_acc only.
  - Unchanged when both or neither are accepted.
- Flags are pure decodes of the count register. They are never computed from the inputs in the same cycle.
- Simultaneous wr_en and rd_en:
  - When full: only the read is accepted. count goes to DEPTH-1 and wr_overflow pulses.
  - When empty: only the write is accepted. There is no bypass, and rd_underflow pulses.
  - Otherwise: both are accepted and count is unchanged.
- FWFT=0:
  - data_out is a register loaded with mem[rd_ptr] on rd_acc.
  - It holds its value otherwise, including when empty.
- FWFT=1:
  - data_out = mem[rd_ptr] while ~rd_empty, else 0.
  - rd_en acknowledges (pops) the word already on data_out.
- wr_overflow <= wr_en & wr_full. rd_underflow <= rd_en & rd_empty. Both are registered.
- Memory contents are not reset. Reset discards all stored data.

## Timing
- Reset (reset_n low, asynchronous) forces:
  - wr_ptr = rd_ptr = count = 0 and data_out = 0.
  - rd_empty = 1, wr_full = 0, wr_almost_full = (AF_TH == 0 ? 1 : 0), rd_almost_empty = 1.
  - wr_overflow = rd_underflow = 0.
- Reset asserted mid-operation takes effect immediately, with no clock edge needed. Release is synchronous to the next rising clk edge.
- Write latency:
  - A word written at edge N is readable at edge N+1: rd_empty falls after edge N, and rd_acc is possible at edge N+1.
  - FWFT=1: data_out is valid after edge N.
  - FWFT=0: data_out is valid after the edge at which rd_acc occurs.
- Flag and count latency: all flags and count change on the edge that accepts the operation and are stable for the whole following cycle.
- Error pulses: wr_overflow and rd_underflow are high for exactly the cycle after the rejected request.
- Throughput: one write and one read per cycle, sustained, at any occupancy except the full/empty boundaries above.

## Structure
- Package fifo_pkg:
  - Function clog2-style ptr_w(depth).
  - Localparam DEPTH derivation.
  - Enumerated read-mode constants MODE_REG = 0 and MODE_FWFT = 1.
- Sub-module fifo_mem: DEPTH×WIDTH storage with a synchronous write port and an asynchronous read port.
  - The top level holds pointers, count, flags, the error registers and the FWFT=0 output register.
- Parameter checks, which must fail elaboration when violated:
  - AF_TH ≤ DEPTH.
  - AE_TH < DEPTH.
  - FWFT ∈ {0,1}.

## Test plan
- Reset/defaults: hold reset_n=0 for 3 cycles, then release → count=0, rd_empty=1, wr_full=0, data_out=0. Assert reset_n mid-burst with count=5 → count=0 and rd_empty=1 immediately, before any clock edge.
- Fill/drain at defaults (FWFT=0): write 0x00..0x0F in 16 cycles, then read 16.
  - After the 16th write: wr_full=1, count=16, and wr_almost_full is set from count 14.
  - Reads return 0x00..0x0F in order, each on data_out the cycle after its rd_acc.
  - After the last read: rd_empty=1.
- Overflow/underflow: write while full → data unchanged, count=16, wr_overflow high for exactly 1 cycle. Read while empty → rd_underflow for 1 cycle, count stays 0.
- Simultaneous operations, three cases:
  - Full with wr_en+rd_en → count=15, oldest word popped, wr_overflow=1.
  - Empty with both → count=1, rd_underflow=1.
  - count=7 with both for 50 cycles → count stays 7 and the data order is preserved across pointer wrap.
- FWFT=1, WIDTH=32, POINTER=3:
  - Write 0xDEADBEEF → data_out=0xDEADBEEF the cycle after, with no rd_en.
  - rd_en pops it → data_out=0 and rd_empty=1.
- Thresholds with AF_TH=5, AE_TH=1: ramp count 0→8→0 → wr_almost_full is high exactly for count ≥5, and rd_almost_empty is high exactly for count ≤1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised single-clock FIFO:
// sizing helpers and the read-mode encoding.
package fifo_pkg;

  typedef enum logic {
    MODE_REG  = 1'b0,
    MODE_FWFT = 1'b1
  } rd_mode_e;

  localparam int DEF_POINTER = 4;

  function automatic int ptr_w(input int depth);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) < depth) begin
        w = i + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

  function automatic int depth_of(input int pointer);
    return 32'sd1 <<< pointer;
  endfunction

  localparam int DEF_DEPTH = depth_of(DEF_POINTER);

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: synchronous write port, asynchronous read port.
// Contents are intentionally not reset.
module fifo_mem #(
  parameter int WIDTH   = 8,
  parameter int POINTER = 4
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [POINTER-1:0] waddr_i,
  input  logic [WIDTH-1:0]   wdata_i,
  input  logic [POINTER-1:0] raddr_i,
  output logic [WIDTH-1:0]   rdata_o
);

  logic [WIDTH-1:0] mem_q [0:(1<<POINTER)-1];

  // Write port
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with count, threshold flags, error pulses and a
// selectable registered or first-word-fall-through read port.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int POINTER = DEF_POINTER,
  parameter int AF_TH   = depth_of(POINTER) - 2,
  parameter int AE_TH   = 2,
  parameter int FWFT    = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] data_in,
  output logic             wr_full,
  output logic             wr_almost_full,
  output logic             wr_overflow,
  input  logic             rd_en,
  output logic [WIDTH-1:0] data_out,
  output logic             rd_empty,
  output logic             rd_almost_empty,
  output logic             rd_underflow,
  output logic [POINTER:0] count
);

  localparam int DEPTH = depth_of(POINTER);
  localparam int CW    = POINTER + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_TH);
  localparam logic [CW-1:0] AE_C   = CW'(AE_TH);

  if (WIDTH < 1 || POINTER < 1) begin : g_size_chk
    $error("sync_fifo_param: WIDTH and POINTER must be >= 1");
  end
  if (AF_TH > DEPTH) begin : g_af_chk
    $error("sync_fifo_param: AF_TH must not exceed DEPTH");
  end
  if (AE_TH >= DEPTH) begin : g_ae_chk
    $error("sync_fifo_param: AE_TH must be below DEPTH");
  end
  if (FWFT != int'(MODE_REG) && FWFT != int'(MODE_FWFT)) begin : g_mode_chk
    $error("sync_fifo_param: FWFT must be 0 or 1");
  end
  if (ptr_w(DEPTH) != POINTER) begin : g_ptr_chk
    $error("sync_fifo_param: pointer width inconsistent with DEPTH");
  end

  logic [POINTER-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   dout_q, dout_d, rd_word_s;
  logic               wr_ovf_q, rd_unf_q;
  logic               wr_acc_s, rd_acc_s;

  // Flags decode only the registered count, never the current requests.
  assign wr_full         = (count_q == FULL_C);
  assign rd_empty        = (count_q == CW'(0));
  assign wr_almost_full  = (count_q >= AF_C);
  assign rd_almost_empty = (count_q <= AE_C);
  assign count           = count_q;
  assign wr_overflow     = wr_ovf_q;
  assign rd_underflow    = rd_unf_q;

  assign wr_acc_s = wr_en & ~wr_full;
  assign rd_acc_s = rd_en & ~rd_empty;

  fifo_mem #(.WIDTH(WIDTH), .POINTER(POINTER)) u_mem (
    .clk_i   (clk),
    .we_i    (wr_acc_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_word_s)
  );

  // Next-state for pointers, occupancy and the registered read word
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    if (wr_acc_s) begin
      wr_ptr_d = wr_ptr_q + POINTER'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_acc_s) begin
      rd_ptr_d = rd_ptr_q + POINTER'(1'b1);
      dout_d   = rd_word_s;
    end else begin
      rd_ptr_d = rd_ptr_q;
      dout_d   = dout_q;
    end
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_d = count_q + CW'(1'b1);
      2'b01:   count_d = count_q - CW'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= POINTER'(1'b0);
      rd_ptr_q <= POINTER'(1'b0);
      count_q  <= CW'(1'b0);
      dout_q   <= WIDTH'(1'b0);
      wr_ovf_q <= 1'b0;
      rd_unf_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      wr_ovf_q <= wr_en & wr_full;
      rd_unf_q <= rd_en & rd_empty;
    end
  end

  // In fall-through mode the head word is shown directly, zero when empty
  always_comb begin
    data_out = dout_q;
    if (FWFT == int'(MODE_FWFT)) begin
      if (rd_empty) begin
        data_out = WIDTH'(1'b0);
      end else begin
        data_out = rd_word_s;
      end
    end else begin
      data_out = dout_q;
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: default, FWFT/32-bit and custom
// threshold configurations share one clock and reset.
module tb_sync_fifo_param;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        wr_en [3];
  logic        rd_en [3];
  logic [31:0] din   [3];

  logic [31:0] dout_w [3];
  logic [31:0] cnt_w  [3];
  logic        full_w [3], af_w [3], ovf_w [3], empty_w [3], ae_w [3], unf_w [3];

  logic [7:0]  dout_a, dout_c;
  logic [31:0] dout_b;
  logic [4:0]  cnt_a;
  logic [3:0]  cnt_b, cnt_c;

  int          depth_c [3] = '{16, 8, 8};
  int          af_c    [3] = '{14, 6, 5};
  int          ae_c    [3] = '{2, 2, 1};
  int          fwft_c  [3] = '{0, 1, 0};
  logic [31:0] mask_c  [3] = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h0000_00FF};

  logic [31:0] sb [$];
  logic [31:0] last_dout [3];
  int n_cmp = 0;
  int n_err = 0;

  sync_fifo_param u_a (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en[0]), .data_in(din[0][7:0]),
    .wr_full(full_w[0]), .wr_almost_full(af_w[0]), .wr_overflow(ovf_w[0]),
    .rd_en(rd_en[0]), .data_out(dout_a), .rd_empty(empty_w[0]),
    .rd_almost_empty(ae_w[0]), .rd_underflow(unf_w[0]), .count(cnt_a));

  sync_fifo_param #(.WIDTH(32), .POINTER(3), .FWFT(1)) u_b (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en[1]), .data_in(din[1]),
    .wr_full(full_w[1]), .wr_almost_full(af_w[1]), .wr_overflow(ovf_w[1]),
    .rd_en(rd_en[1]), .data_out(dout_b), .rd_empty(empty_w[1]),
    .rd_almost_empty(ae_w[1]), .rd_underflow(unf_w[1]), .count(cnt_b));

  sync_fifo_param #(.WIDTH(8), .POINTER(3), .AF_TH(5), .AE_TH(1)) u_c (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en[2]), .data_in(din[2][7:0]),
    .wr_full(full_w[2]), .wr_almost_full(af_w[2]), .wr_overflow(ovf_w[2]),
    .rd_en(rd_en[2]), .data_out(dout_c), .rd_empty(empty_w[2]),
    .rd_almost_empty(ae_w[2]), .rd_underflow(unf_w[2]), .count(cnt_c));

  assign dout_w[0] = {24'd0, dout_a};
  assign dout_w[1] = dout_b;
  assign dout_w[2] = {24'd0, dout_c};
  assign cnt_w[0]  = {27'd0, cnt_a};
  assign cnt_w[1]  = {28'd0, cnt_b};
  assign cnt_w[2]  = {28'd0, cnt_c};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input int k, input logic exp_ovf, input logic exp_unf);
    int n;
    logic [31:0] exp_d;
    n = sb.size();
    if (fwft_c[k] == 1) exp_d = (n == 0) ? 32'd0 : sb[0];
    else                exp_d = last_dout[k];
    check_val($sformatf("u%0d count", k), cnt_w[k], 32'(n));
    check_val($sformatf("u%0d full", k), {31'd0, full_w[k]}, {31'd0, n == depth_c[k]});
    check_val($sformatf("u%0d empty", k), {31'd0, empty_w[k]}, {31'd0, n == 0});
    check_val($sformatf("u%0d afull", k), {31'd0, af_w[k]}, {31'd0, n >= af_c[k]});
    check_val($sformatf("u%0d aempty", k), {31'd0, ae_w[k]}, {31'd0, n <= ae_c[k]});
    check_val($sformatf("u%0d overflow", k), {31'd0, ovf_w[k]}, {31'd0, exp_ovf});
    check_val($sformatf("u%0d underflow", k), {31'd0, unf_w[k]}, {31'd0, exp_unf});
    check_val($sformatf("u%0d data_out", k), dout_w[k], exp_d);
  endtask

  // One clock cycle on instance k; the scoreboard is updated as stimulus is driven.
  task automatic cyc(input int k, input logic we, input logic [31:0] d, input logic re);
    int n;
    logic wacc, racc, eo, eu;
    logic [31:0] popped;
    n = sb.size();
    wacc = we && (n != depth_c[k]);
    racc = re && (n != 0);
    eo = we && (n == depth_c[k]);
    eu = re && (n == 0);
    wr_en[k] = we; din[k] = d; rd_en[k] = re;
    if (racc) begin
      popped = sb.pop_front();
      if (fwft_c[k] == 0) last_dout[k] = popped;
    end
    if (wacc) sb.push_back(d & mask_c[k]);
    @(posedge clk); #1;
    wr_en[k] = 1'b0; rd_en[k] = 1'b0;
    check_all(k, eo, eu);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      wr_en[k] = 1'b0; rd_en[k] = 1'b0; din[k] = 32'd0; last_dout[k] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) check_all(k, 1'b0, 1'b0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) check_all(k, 1'b0, 1'b0);

    // Fill and drain, default configuration
    for (int i = 0; i < 16; i++) cyc(0, 1'b1, 32'(i), 1'b0);
    for (int i = 0; i < 16; i++) cyc(0, 1'b0, 32'd0, 1'b1);

    // Overflow while full, then simultaneous request while full
    for (int i = 0; i < 16; i++) cyc(0, 1'b1, 32'(8'h40 + i), 1'b0);
    cyc(0, 1'b1, 32'h0000_00AA, 1'b0);
    cyc(0, 1'b0, 32'd0, 1'b0);
    cyc(0, 1'b1, 32'h0000_00BB, 1'b1);
    cyc(0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 15; i++) cyc(0, 1'b0, 32'd0, 1'b1);

    // Underflow while empty, then simultaneous request while empty
    cyc(0, 1'b0, 32'd0, 1'b1);
    cyc(0, 1'b0, 32'd0, 1'b0);
    cyc(0, 1'b1, 32'h0000_0077, 1'b1);
    cyc(0, 1'b0, 32'd0, 1'b0);

    // Steady state at count 7 across pointer wrap
    for (int i = 0; i < 6; i++) cyc(0, 1'b1, 32'(8'h80 + i), 1'b0);
    for (int i = 0; i < 50; i++) cyc(0, 1'b1, 32'($urandom_range(0, 255)), 1'b1);
    for (int i = 0; i < 7; i++) cyc(0, 1'b0, 32'd0, 1'b1);

    // Fall-through, 32-bit, depth 8
    cyc(1, 1'b1, 32'hDEAD_BEEF, 1'b0);
    cyc(1, 1'b0, 32'd0, 1'b0);
    cyc(1, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 9; i++) cyc(1, 1'b1, 32'h1234_0000 + 32'(i), 1'b0);
    for (int i = 0; i < 4; i++) cyc(1, 1'b1, 32'hCAFE_0000 + 32'(i), 1'b1);
    for (int i = 0; i < 9; i++) cyc(1, 1'b0, 32'd0, 1'b1);

    // Threshold ramp 0 -> 8 -> 0 with AF_TH=5, AE_TH=1
    for (int i = 0; i < 8; i++) cyc(2, 1'b1, 32'(i * 3), 1'b0);
    for (int i = 0; i < 8; i++) cyc(2, 1'b0, 32'd0, 1'b1);

    // Asynchronous reset in the middle of a burst at count 5
    for (int i = 0; i < 5; i++) cyc(0, 1'b1, 32'(8'hC0 + i), 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("async rst count", cnt_w[0], 32'd0);
    check_val("async rst empty", {31'd0, empty_w[0]}, 32'd1);
    check_val("async rst data_out", dout_w[0], 32'd0);
    sb.delete();
    for (int k = 0; k < 3; k++) last_dout[k] = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_all(0, 1'b0, 1'b0);
    cyc(0, 1'b1, 32'h0000_005A, 1'b0);
    cyc(0, 1'b0, 32'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
